// File: rtl/firmware_pkg.sv
// Shared constants and encodings for the firmware ROM arbiter.
package firmware_pkg;

  localparam int unsigned FW_ADDR_W   = 14;
  localparam int unsigned FW_ROM_SIZE = 'h3000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DMA  = 2'd2
  } grant_e;

endpackage

// File: rtl/firmware_arbiter_m.sv
// Arbitrates the firmware ROM between CPU reads and a DMA burst engine.
// The CPU normally has priority; a pending burst that has been denied
// MAX_WAIT times gets one forced grant while the CPU is stalled.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no burst pending; dma_start with a non-zero length arms one
// ST_BURST | burst active; reads dma_base+index on every DMA grant
module firmware_arbiter_m
  import firmware_pkg::*;
#(
  parameter int unsigned        ADDR_W   = FW_ADDR_W,
  parameter logic [ADDR_W-1:0]  ROM_SIZE = ADDR_W'(FW_ROM_SIZE),
  parameter int unsigned        MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_select_firmware,
  input  logic              cpu_select_vectors,
  output logic              cpu_stall,
  output logic [7:0]        cpu_data,
  output logic              cpu_valid,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] dma_base,
  input  logic [ADDR_W-1:0] dma_len,
  output logic [7:0]        dma_data,
  output logic              dma_valid,
  output logic              dma_busy,
  output logic              dma_done,
  output logic              dma_error,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_select_firmware,
  output logic              rom_select_vectors,
  input  logic [7:0]        rom_data
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  burst_state_e      r_state;
  burst_state_e      w_state_nxt;
  grant_e            w_grant;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_idx;
  logic [WAIT_W-1:0] r_wait;
  logic [7:0]        r_cpu_data;
  logic [7:0]        r_dma_data;
  logic              r_cpu_valid;
  logic              r_dma_valid;
  logic              r_dma_done;
  logic              r_dma_error;

  logic              w_cpu_req;
  logic              w_in_burst;
  logic              w_force;
  logic [ADDR_W-1:0] w_dma_addr;
  logic              w_dma_oob;
  logic              w_dma_last;
  logic              w_dma_read;
  logic              w_start_ok;
  logic              w_start_empty;

  // Grant decision, ROM mux and burst next-state
  always_comb begin
    w_cpu_req     = cpu_select_firmware | cpu_select_vectors;
    w_in_burst    = (r_state == ST_BURST);
    w_force       = w_in_burst && (r_wait >= WAIT_W'(MAX_WAIT));
    // Address wraps naturally at 2^ADDR_W.
    w_dma_addr    = r_base + r_idx;
    w_dma_oob     = (w_dma_addr >= ROM_SIZE);
    w_dma_last    = (r_idx == r_len - ADDR_W'(1));
    w_start_ok    = (r_state == ST_IDLE) && dma_start && (dma_len != '0);
    w_start_empty = (r_state == ST_IDLE) && dma_start && (dma_len == '0);

    w_grant = GNT_NONE;
    if (w_force)          w_grant = GNT_DMA;
    else if (w_cpu_req)   w_grant = GNT_CPU;
    else if (w_in_burst)  w_grant = GNT_DMA;

    w_dma_read          = (w_grant == GNT_DMA) && !w_dma_oob;
    rom_address         = '0;
    rom_select_firmware = 1'b0;
    rom_select_vectors  = 1'b0;
    case (w_grant)
      GNT_CPU: begin
        rom_address         = cpu_address;
        // Firmware wins if the CPU raises both selects.
        rom_select_firmware = cpu_select_firmware;
        rom_select_vectors  = cpu_select_vectors & ~cpu_select_firmware;
      end
      GNT_DMA: begin
        rom_address         = w_dma_addr;
        rom_select_firmware = !w_dma_oob;
      end
      default: ;
    endcase

    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_state_nxt = ST_BURST;
      ST_BURST: if (w_grant == GNT_DMA && (w_dma_oob || w_dma_last)) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State, burst bookkeeping and registered read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_wait      <= '0;
      r_cpu_data  <= '0;
      r_dma_data  <= '0;
      r_cpu_valid <= 1'b0;
      r_dma_valid <= 1'b0;
      r_dma_done  <= 1'b0;
      r_dma_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cpu_valid <= (w_grant == GNT_CPU);
      r_dma_valid <= w_dma_read;
      r_dma_done  <= w_start_empty || (w_dma_read && w_dma_last);
      r_dma_error <= (w_grant == GNT_DMA) && w_dma_oob;
      if (w_grant == GNT_CPU) r_cpu_data <= rom_data;
      if (w_dma_read)         r_dma_data <= rom_data;

      if (w_start_ok) begin
        r_base <= dma_base;
        r_len  <= dma_len;
        r_idx  <= '0;
      end else if (w_grant == GNT_DMA) begin
        r_idx  <= r_idx + ADDR_W'(1);
      end

      if (w_grant == GNT_DMA)
        r_wait <= '0;
      else if (w_in_burst && w_grant == GNT_CPU && r_wait < WAIT_W'(MAX_WAIT))
        r_wait <= r_wait + WAIT_W'(1);
    end
  end

  assign cpu_stall = w_force && w_cpu_req;
  assign cpu_data  = r_cpu_data;
  assign cpu_valid = r_cpu_valid;
  assign dma_data  = r_dma_data;
  assign dma_valid = r_dma_valid;
  assign dma_busy  = w_in_burst;
  assign dma_done  = r_dma_done;
  assign dma_error = r_dma_error;

endmodule

// File: doc/firmware_arbiter_m.md
FIRMWARE_ARBITER_M -- requirements
Module: firmware_arbiter_m

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning the ROM address width.
REQ-002 SHALL have parameter ROM_SIZE, default 14'h3000, meaning the number of firmware bytes.
REQ-003 SHALL have parameter MAX_WAIT, default 8, meaning the maximum number of cycles a pending DMA read may be deferred.
REQ-004 SHALL have port clk, input, 1, the single system clock.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port cpu_address, input, ADDR_W, the CPU read address.
REQ-007 SHALL have port cpu_select_firmware, input, 1, CPU firmware read request.
REQ-008 SHALL have port cpu_select_vectors, input, 1, CPU vector read request.
REQ-009 SHALL have port cpu_stall, output, 1, CPU must hold its request (drives RDY low).
REQ-010 SHALL have port cpu_data, output, 8, registered CPU read data.
REQ-011 SHALL have port cpu_valid, output, 1, cpu_data is valid this cycle.
REQ-012 SHALL have port dma_start, input, 1, one-cycle pulse that launches a burst.
REQ-013 SHALL have port dma_base, input, ADDR_W, burst start address, sampled on dma_start.
REQ-014 SHALL have port dma_len, input, ADDR_W, burst byte count, sampled on dma_start.
REQ-015 SHALL have port dma_data, output, 8, registered burst byte.
REQ-016 SHALL have port dma_valid, output, 1, dma_data is valid this cycle.
REQ-017 SHALL have ports dma_busy, dma_done and dma_error, output, 1 each: burst active, completion pulse, and out-of-range abort pulse.
REQ-018 SHALL have ports rom_address (output, ADDR_W), rom_select_firmware (output, 1), rom_select_vectors (output, 1) and rom_data (input, 8), which drive the combinational-read firmware ROM.

Function
REQ-019 SHALL implement a burst FSM with states IDLE and BURST: IDLE->BURST on dma_start with dma_len!=0; BURST->IDLE when the last byte is captured or on an error.
REQ-020 SHALL treat dma_start with dma_len==0 as a no-op that pulses dma_done the next cycle.
REQ-021 SHALL ignore dma_start while dma_busy=1.
REQ-022 SHALL decide the grant combinationally each cycle: CPU if it is requesting, else DMA if in BURST, else none.
REQ-023 SHALL count the cycles in which BURST has been denied; on reaching MAX_WAIT, the next cycle SHALL be a forced DMA grant with cpu_stall=1, after which the counter clears.
REQ-024 SHALL clear the wait counter on every DMA grant.
REQ-025 SHALL mux the granted address and select onto the rom_* ports combinationally, with DMA asserting rom_select_firmware only and no grant giving all selects 0.
REQ-026 SHALL capture rom_data into cpu_data or dma_data at the clock edge and assert the matching valid for exactly 1 cycle, giving a latency of 1 cycle.
REQ-027 SHALL assert cpu_valid only in the cycle after a non-stalled CPU grant.
REQ-028 SHALL generate each DMA address as dma_base+index and increment the index only on a DMA grant.
REQ-029 SHALL, when a DMA address is >= ROM_SIZE, issue no ROM read, pulse dma_error, and return to IDLE without pulsing dma_done.
REQ-030 SHALL pulse dma_done in the same cycle as the dma_valid of the final byte.
REQ-031 SHALL compute addresses modulo 2^ADDR_W, so that a wrap of dma_base+index produces an address below ROM_SIZE that is read normally.
REQ-032 SHALL never assert rom_select_firmware and rom_select_vectors in the same cycle.

Reset
REQ-033 SHALL, while rst_n=0 at a clock edge, enter IDLE and clear the wait counter, index, cpu_data, dma_data, all valid/done/error outputs, dma_busy and cpu_stall.
REQ-034 SHALL, on a reset mid-burst, abort the burst with no dma_done or dma_error pulse.

Structure
REQ-035 SHALL place the ROM_SIZE constant, the FSM state encoding and the grant encoding (NONE/CPU/DMA) in a shared firmware package.
REQ-036 SHALL use a single sub-module, firmware_m, instantiated at the parent level rather than inside this block.

Verification
REQ-037 SHALL verify a single CPU read: a CPU read of 0x0010 with the ROM holding 0xA9 gives cpu_valid=1 and cpu_data=0xA9 the next cycle, with rom_select_firmware=1 during the request.
REQ-038 SHALL verify an idle-CPU burst: dma_base=0x0100, dma_len=4 with the CPU idle gives 4 consecutive dma_valid pulses with bytes 0x0100..0x0103 and dma_done on the 4th.
REQ-039 SHALL verify starvation relief: a continuous CPU request with a burst pending for 8 cycles gives cpu_stall=1 in cycle 9, one DMA byte, then the CPU regains the grant.
REQ-040 SHALL verify the out-of-range abort: dma_base=0x2FFE, dma_len=4 gives 2 bytes, then dma_error=1, dma_busy=0 and no dma_done.
REQ-041 SHALL verify a reset mid-burst: rst_n low during byte 2 of an 8-byte burst gives all outputs 0 the next cycle and no done.
REQ-042 SHALL verify the start edge cases: dma_start with len=0 gives dma_done the next cycle, and dma_start while busy leaves the byte count and addresses unchanged.
